ift_sync_fifo: RTL and testbench

Information-flow-tracking (IFT) instrumented synchronous FIFO with a registered read port. Every data and control signal carries a 32-bit taint label alongside its value. The block is the reader-side counterpart to our IFT flip-flop cells: it stores tainted words and returns them with their labels, and it adds the implicit-flow taint from the read/write controls and the pointer state. It is used as a golden test design for the IFT instrumentation flow.

---
 rtl/ift_pkg.sv | 19 +
 rtl/ift_sync_fifo_if.sv | 35 +++
 rtl/ift_sync_fifo.sv | 98 +++++++++
 tb/tb_ift_sync_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ift_pkg.sv
// Shared taint-label definitions for the IFT-instrumented cells.
package ift_pkg;

  localparam int unsigned TAINT_W = 32;
  localparam logic [TAINT_W-1:0] TAINT_ZERO = '0;

  // Widest data word the X guard accepts; narrower words are zero-extended.
  localparam int unsigned GUARD_W = 64;

  // A word whose value is unknown carries no meaningful label, so its taint is dropped.
  function automatic logic [TAINT_W-1:0] taint_x_guard(input logic [GUARD_W-1:0] data,
                                                       input logic [TAINT_W-1:0] taint);
    if ((^data) === 1'bx) begin
      return TAINT_ZERO;
    end
    return taint;
  endfunction

endpackage

// File: rtl/ift_sync_fifo_if.sv
// Write/read handshake of the IFT FIFO, every signal paired with its taint label.
interface ift_sync_fifo_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAINT_W = 32
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic               wr_en;
    logic [TAINT_W-1:0] wr_en_t;
    logic [WIDTH-1:0]   wr_data;
    logic [TAINT_W-1:0] wr_data_t;
    logic               rd_en;
    logic [TAINT_W-1:0] rd_en_t;
    logic [WIDTH-1:0]   rd_data;
    logic [TAINT_W-1:0] rd_data_t;
    logic               rd_valid;
    logic [TAINT_W-1:0] rd_valid_t;
    logic               full;
    logic [TAINT_W-1:0] full_t;
    logic               empty;
    logic [TAINT_W-1:0] empty_t;
    logic [AW:0]        count;

    modport master (
        output wr_en, wr_en_t, wr_data, wr_data_t, rd_en, rd_en_t,
        input  rd_data, rd_data_t, rd_valid, rd_valid_t, full, full_t, empty, empty_t, count
    );

    modport slave (
        input  wr_en, wr_en_t, wr_data, wr_data_t, rd_en, rd_en_t,
        output rd_data, rd_data_t, rd_valid, rd_valid_t, full, full_t, empty, empty_t, count
    );

endinterface

// File: rtl/ift_sync_fifo.sv
// IFT-instrumented synchronous FIFO with registered read port; labels travel with the data
// and control/pointer activity adds implicit-flow taint to flags and read results.
module ift_sync_fifo
    import ift_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAINT_W = ift_pkg::TAINT_W
) (
    input  logic               pos_clk,
    input  logic [TAINT_W-1:0] pos_clk_t,
    input  logic               pos_arst,
    input  logic [TAINT_W-1:0] pos_arst_t,
    ift_sync_fifo_if.slave     bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q   [DEPTH];
    logic [TAINT_W-1:0] mem_t_q [DEPTH];

    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [AW:0]        count_q, count_d;
    logic [TAINT_W-1:0] ctrl_t_q, ctrl_t_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [TAINT_W-1:0] rd_data_t_q, rd_data_t_d;
    logic               rd_valid_q, rd_valid_d;
    logic [TAINT_W-1:0] rd_valid_t_q, rd_valid_t_d;

    logic               full, empty, wr_acc, rd_acc;
    logic [TAINT_W-1:0] wr_en_lbl, rd_en_lbl, wr_entry_t;

    // Clock taint is deliberately not propagated.
    logic unused_clk_t;
    assign unused_clk_t = ^pos_clk_t;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        wr_acc     = bus.wr_en & ~full;
        rd_acc     = bus.rd_en & ~empty;
        wr_en_lbl  = bus.wr_en ? bus.wr_en_t : TAINT_ZERO;
        rd_en_lbl  = bus.rd_en ? bus.rd_en_t : TAINT_ZERO;
        wr_entry_t = taint_x_guard(GUARD_W'(bus.wr_data), bus.wr_data_t | bus.wr_en_t);

        wptr_d  = wr_acc ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = rd_acc ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);

        // Rejected requests still reveal occupancy, so any asserted request taints control.
        ctrl_t_d = ctrl_t_q | wr_en_lbl | rd_en_lbl;

        rd_data_d    = rd_acc ? mem_q[rptr_q] : rd_data_q;
        rd_data_t_d  = rd_acc ? (mem_t_q[rptr_q] | bus.rd_en_t | ctrl_t_q) : rd_data_t_q;
        rd_valid_d   = rd_acc;
        rd_valid_t_d = ctrl_t_q | rd_en_lbl;
    end

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            mem_q        <= '{default: '0};
            mem_t_q      <= '{default: pos_arst_t};
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            ctrl_t_q     <= pos_arst_t;
            rd_data_q    <= '0;
            rd_data_t_q  <= pos_arst_t;
            rd_valid_q   <= 1'b0;
            rd_valid_t_q <= pos_arst_t;
        end else begin
            if (wr_acc) begin
                mem_q[wptr_q]   <= bus.wr_data;
                mem_t_q[wptr_q] <= wr_entry_t;
            end
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            ctrl_t_q     <= ctrl_t_d;
            rd_data_q    <= rd_data_d;
            rd_data_t_q  <= rd_data_t_d;
            rd_valid_q   <= rd_valid_d;
            rd_valid_t_q <= rd_valid_t_d;
        end
    end

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.full_t     = ctrl_t_q;
    assign bus.empty_t    = ctrl_t_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_data_t  = rd_data_t_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_valid_t = rd_valid_t_q;

endmodule

// File: tb/tb_ift_sync_fifo.sv
// Scoreboard bench for ift_sync_fifo: stimulus queues expected read words, a monitor checks them.
module tb_ift_sync_fifo;

    typedef struct {
        logic [7:0]  d;
        logic [31:0] t;
    } exp_t;

    logic        pos_clk = 1'b0;
    logic [31:0] pos_clk_t = 32'h0;
    logic        pos_arst = 1'b1;
    logic [31:0] pos_arst_t = 32'h1;

    int n_chk  = 0;
    int n_pass = 0;
    exp_t sb_q[$];

    ift_sync_fifo_if #(.WIDTH(8), .DEPTH(4), .TAINT_W(32)) bus ();

    ift_sync_fifo #(.WIDTH(8), .DEPTH(4), .TAINT_W(32)) dut (
        .pos_clk    (pos_clk),
        .pos_clk_t  (pos_clk_t),
        .pos_arst   (pos_arst),
        .pos_arst_t (pos_arst_t),
        .bus        (bus)
    );

    always #5 pos_clk = ~pos_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Applies one set of requests across the next rising edge; returns on the following negedge.
    task automatic drive(input logic we, input logic [7:0] wd, input logic [31:0] wdt,
                         input logic [31:0] wet, input logic re, input logic [31:0] ret);
        bus.wr_en     = we;
        bus.wr_data   = wd;
        bus.wr_data_t = wdt;
        bus.wr_en_t   = wet;
        bus.rd_en     = re;
        bus.rd_en_t   = ret;
        @(negedge pos_clk);
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic push(input logic [7:0] d, input logic [31:0] t);
        exp_t e;
        e.d = d;
        e.t = t;
        sb_q.push_back(e);
    endtask

    always @(negedge pos_clk) begin
        if (!pos_arst && bus.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_rd_valid", 32'(bus.rd_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rd_data", 32'(bus.rd_data), 32'(e.d));
                chk("rd_data_t", bus.rd_data_t, e.t);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] xw;
        logic       xg;

        bus.wr_en = 0; bus.wr_data = 0; bus.wr_data_t = 0; bus.wr_en_t = 0;
        bus.rd_en = 0; bus.rd_en_t = 0;

        // 1: reset release
        @(negedge pos_clk);
        @(negedge pos_clk);
        pos_arst = 1'b0;
        #1;
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_empty_t", bus.empty_t, 32'h1);
        chk("rst_rd_data_t", bus.rd_data_t, 32'h1);
        chk("rst_rd_valid_t", bus.rd_valid_t, 32'h1);
        @(negedge pos_clk);

        // 2: single write/read, taint 4 | ctrl 1
        drive(1, 8'hA5, 32'h4, 32'h0, 0, 32'h0);
        chk("t2_count_wr", 32'(bus.count), 32'h1);
        push(8'hA5, 32'h5);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        chk("t2_rd_valid", 32'(bus.rd_valid), 32'h1);
        chk("t2_count_rd", 32'(bus.count), 32'h0);
        idle();
        chk("t2_rd_valid_drop", 32'(bus.rd_valid), 32'h0);

        // 3: fill, overflow rejected, drain in order
        drive(1, 8'h11, 32'h10, 32'h0, 0, 32'h0);
        drive(1, 8'h22, 32'h20, 32'h0, 0, 32'h0);
        drive(1, 8'h33, 32'h40, 32'h0, 0, 32'h0);
        drive(1, 8'h44, 32'h80, 32'h0, 0, 32'h0);
        chk("t3_full", 32'(bus.full), 32'h1);
        chk("t3_count4", 32'(bus.count), 32'h4);
        drive(1, 8'h77, 32'h200, 32'h0, 0, 32'h0);
        chk("t3_count_after_ovf", 32'(bus.count), 32'h4);
        chk("t3_full_t", bus.full_t, 32'h1);
        push(8'h11, 32'h11);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        push(8'h22, 32'h21);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        push(8'h33, 32'h41);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        push(8'h44, 32'h81);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        idle();
        chk("t3_empty", 32'(bus.empty), 32'h1);
        chk("t3_count0", 32'(bus.count), 32'h0);

        // 4: simultaneous read/write at full and at empty
        drive(1, 8'h55, 32'h0, 32'h0, 0, 32'h0);
        drive(1, 8'h66, 32'h0, 32'h0, 0, 32'h0);
        drive(1, 8'h77, 32'h0, 32'h0, 0, 32'h0);
        drive(1, 8'h88, 32'h0, 32'h0, 0, 32'h0);
        push(8'h55, 32'h1);
        drive(1, 8'h99, 32'h0, 32'h0, 1, 32'h0);
        chk("t4_count_full_rw", 32'(bus.count), 32'h3);
        chk("t4_full_drop", 32'(bus.full), 32'h0);
        push(8'h66, 32'h1);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        push(8'h77, 32'h1);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        push(8'h88, 32'h1);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        chk("t4_empty", 32'(bus.empty), 32'h1);
        drive(1, 8'hAB, 32'h8, 32'h0, 1, 32'h0);
        chk("t4_count_empty_rw", 32'(bus.count), 32'h1);
        chk("t4_rd_valid_empty_rw", 32'(bus.rd_valid), 32'h0);
        push(8'hAB, 32'h9);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        idle();

        // 5: read of empty still taints control
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h100);
        chk("t5_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("t5_empty_t", bus.empty_t, 32'h101);
        chk("t5_full_t", bus.full_t, 32'h101);
        chk("t5_rd_valid_t", bus.rd_valid_t, 32'h101);
        drive(1, 8'hCD, 32'h0, 32'h0, 0, 32'h0);
        push(8'hCD, 32'h101);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        idle();

        // 6: unknown write data loses its own label
        xw = 8'bxxxx0000;
        xg = ((^xw) === 1'bx);
        drive(1, xw, 32'hF, 32'h0, 0, 32'h0);
        push(xw, xg ? 32'h101 : 32'h10F);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        drive(1, 8'h12, 32'h0, 32'h0, 0, 32'h0);
        drive(1, 8'h34, 32'h0, 32'h0, 0, 32'h0);
        push(8'h12, 32'h101);
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        chk("t6_pre_rst_valid", 32'(bus.rd_valid), 32'h1);
        chk("t6_pre_rst_count", 32'(bus.count), 32'h1);

        // Asynchronous reset between edges
        #2;
        pos_arst_t = 32'h20;
        pos_arst   = 1'b1;
        #1;
        chk("arst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("arst_rd_data", 32'(bus.rd_data), 32'h0);
        chk("arst_count", 32'(bus.count), 32'h0);
        chk("arst_empty", 32'(bus.empty), 32'h1);
        chk("arst_empty_t", bus.empty_t, 32'h20);
        chk("arst_full_t", bus.full_t, 32'h20);
        chk("arst_rd_data_t", bus.rd_data_t, 32'h20);
        chk("arst_rd_valid_t", bus.rd_valid_t, 32'h20);
        @(negedge pos_clk);
        pos_arst = 1'b0;
        drive(0, 8'h00, 32'h0, 32'h0, 1, 32'h0);
        chk("post_rst_rd_ignored", 32'(bus.rd_valid), 32'h0);
        chk("post_rst_rd_valid_t", bus.rd_valid_t, 32'h20);
        idle();

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
